// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive front end.
package usb_rx_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 8;
  localparam int unsigned DEF_SAMPLE_POINT = 3;

  // Value a correctly received SYNC pattern (KJKJKJKK) assembles to.
  localparam logic [7:0] USB_SYNC_BYTE = 8'h80;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    SE0_1  = 2'd2,
    WAIT_J = 2'd3
  } rx_state_e;

  // Line state as {D+, D-}.
  typedef enum logic [1:0] {
    LS_SE0 = 2'b00,
    LS_K   = 2'b01,
    LS_J   = 2'b10,
    LS_SE1 = 2'b11
  } line_state_e;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: free-running modulo counter, re-aligned on every line
// edge, producing a sample strobe at a fixed phase inside the bit.
module rx_bit_timer
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned SAMPLE_POINT = DEF_SAMPLE_POINT
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic reload_i,
  output logic strobe_c_o
);

  localparam int unsigned TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] SAMP = TW'(SAMPLE_POINT);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  // Next count: reload on edge, otherwise wrap at the end of the bit period.
  always_comb begin
    timer_d = timer_q + TW'(1);
    if (reload_i || (timer_q == LAST)) begin
      timer_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // An edge in the sampling cycle re-aligns the timer instead of sampling.
  assign strobe_c_o = en_i && !reload_i && (timer_q == SAMP);

endmodule

// File: rtl/rx_bit_decoder.sv
// USB full-speed receive bit decoder: edge detect, bit timing, NRZI decode,
// bit unstuffing, LSB-first byte assembly and EOP / stuff-error flagging.
module rx_bit_decoder
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned SAMPLE_POINT = DEF_SAMPLE_POINT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       d_plus_sync,
  input  logic       d_minus_sync,
  input  logic       enable,
  output logic       d_edge,
  output logic [7:0] Packet_Data,
  output logic       byte_complete,
  output logic       eop,
  output logic       bit_stuff_err
);

  rx_state_e   state_q, state_d;
  logic        dp_dly_q;
  logic        edge_q;
  logic        prev_dp_q, prev_dp_d;
  logic [2:0]  ones_q, ones_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        bc_q, bc_d;
  logic        eop_q, eop_d;
  logic        err_q, err_d;

  logic        sample_c;
  logic        se0_c;
  logic        dec_bit_c;
  logic        take_bit_c;

  // D+ edge detector; d_edge is also the timer reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_dly_q <= 1'b1;
      edge_q   <= 1'b0;
    end else begin
      dp_dly_q <= d_plus_sync;
      edge_q   <= d_plus_sync ^ dp_dly_q;
    end
  end

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SAMPLE_POINT (SAMPLE_POINT)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en_i       (state_q != IDLE),
    .reload_i   (edge_q),
    .strobe_c_o (sample_c)
  );

  assign se0_c     = ({d_plus_sync, d_minus_sync} == LS_SE0);
  assign dec_bit_c = (d_plus_sync == prev_dp_q);

  // Next-state, unstuffing and byte assembly.
  always_comb begin
    state_d    = state_q;
    prev_dp_d  = prev_dp_q;
    ones_d     = ones_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    data_d     = data_q;
    bc_d       = 1'b0;
    eop_d      = 1'b0;
    err_d      = 1'b0;
    take_bit_c = 1'b0;

    case (state_q)
      IDLE: begin
        state_d   = RECV;
        prev_dp_d = 1'b1;
        ones_d    = '0;
        bit_cnt_d = '0;
      end
      RECV: begin
        if (sample_c) begin
          if (se0_c) begin
            state_d   = SE0_1;
            ones_d    = '0;
            bit_cnt_d = '0;
          end else begin
            take_bit_c = 1'b1;
          end
        end
      end
      SE0_1: begin
        if (sample_c) begin
          if (se0_c) begin
            eop_d   = 1'b1;
            state_d = WAIT_J;
          end else begin
            take_bit_c = 1'b1;
            state_d    = RECV;
          end
        end
      end
      WAIT_J: begin
        if (sample_c && ({d_plus_sync, d_minus_sync} == LS_J)) begin
          prev_dp_d = 1'b1;
          state_d   = RECV;
        end
      end
      default: state_d = IDLE;
    endcase

    // NRZI bit: a stuff bit is consumed, data bits shift into the byte.
    if (take_bit_c) begin
      prev_dp_d = d_plus_sync;
      if (ones_q == 3'd6) begin
        ones_d = '0;
        if (dec_bit_c) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
        end
      end else begin
        ones_d  = dec_bit_c ? (ones_q + 3'd1) : 3'd0;
        shreg_d = {dec_bit_c, shreg_q[7:1]};
        if (bit_cnt_q == 3'd7) begin
          data_d    = {dec_bit_c, shreg_q[7:1]};
          bc_d      = 1'b1;
          bit_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
    end

    // Receive disabled: park in IDLE, suppress pulses, hold the last byte.
    if (!enable) begin
      state_d   = IDLE;
      prev_dp_d = 1'b1;
      ones_d    = '0;
      bit_cnt_d = '0;
      shreg_d   = shreg_q;
      data_d    = data_q;
      bc_d      = 1'b0;
      eop_d     = 1'b0;
      err_d     = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_dp_q <= 1'b1;
      ones_q    <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      bc_q      <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_dp_q <= prev_dp_d;
      ones_q    <= ones_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      bc_q      <= bc_d;
      eop_q     <= eop_d;
      err_q     <= err_d;
    end
  end

  assign d_edge        = edge_q;
  assign Packet_Data   = data_q;
  assign byte_complete = bc_q;
  assign eop           = eop_q;
  assign bit_stuff_err = err_q;

endmodule

// File: tb/tb_rx_bit_decoder.sv
// Directed bench for rx_bit_decoder at 8 clocks per bit.
module tb_rx_bit_decoder;

  localparam int unsigned CPB = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       dp;
  logic       dm;
  logic       enable;
  logic       d_edge;
  logic [7:0] Packet_Data;
  logic       byte_complete;
  logic       eop;
  logic       bit_stuff_err;

  int errors = 0;
  int checks = 0;
  int n_edge = 0;
  int n_bc   = 0;
  int n_eop  = 0;
  int n_err  = 0;
  int s_edge, s_bc, s_eop, s_err;

  rx_bit_decoder #(
    .CLKS_PER_BIT (CPB),
    .SAMPLE_POINT (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .d_plus_sync   (dp),
    .d_minus_sync  (dm),
    .enable        (enable),
    .d_edge        (d_edge),
    .Packet_Data   (Packet_Data),
    .byte_complete (byte_complete),
    .eop           (eop),
    .bit_stuff_err (bit_stuff_err)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (d_edge)        n_edge++;
    if (byte_complete) n_bc++;
    if (eop)           n_eop++;
    if (bit_stuff_err) n_err++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    #1;
    s_edge = n_edge;
    s_bc   = n_bc;
    s_eop  = n_eop;
    s_err  = n_err;
  endtask

  task automatic send_bit(input logic p, input logic m);
    dp = p;
    dm = m;
    repeat (CPB) @(negedge clk);
  endtask

  // KJKJKJK then a final K, checking the exact byte_complete cycle.
  task automatic send_sync(input string tag);
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) send_bit(1'b0, 1'b1);
      else            send_bit(1'b1, 1'b0);
    end
    dp = 1'b0;
    dm = 1'b1;
    repeat (5) @(negedge clk);
    check({tag, ".pre"}, 32'(byte_complete), 32'd0);
    @(negedge clk);
    check({tag, ".bc"}, 32'(byte_complete), 32'd1);
    check({tag, ".data"}, 32'(Packet_Data), 32'h80);
    @(negedge clk);
    check({tag, ".post"}, 32'(byte_complete), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    dp     = 1'b1;
    dm     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.data", 32'(Packet_Data), 32'h00);
    check("rst.bc", 32'(byte_complete), 32'd0);
    check("rst.eop", 32'(eop), 32'd0);
    check("rst.err", 32'(bit_stuff_err), 32'd0);
    check("rst.edge", 32'(d_edge), 32'd0);
    rst = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);

    // SYNC alone
    snap();
    enable = 1'b1;
    send_sync("t1");
    #1;
    check("t1.edges", 32'(n_edge - s_edge), 32'd7);
    check("t1.bytes", 32'(n_bc - s_bc), 32'd1);

    // 0xFF with a stuffed 0 after the sixth consecutive 1
    snap();
    repeat (5) send_bit(1'b0, 1'b1);
    repeat (4) send_bit(1'b1, 1'b0);
    #1;
    check("t2.bytes", 32'(n_bc - s_bc), 32'd1);
    check("t2.data", 32'(Packet_Data), 32'hFF);
    check("t2.err", 32'(n_err - s_err), 32'd0);
    enable = 1'b0;
    send_bit(1'b1, 1'b0);

    // Stuff violation: line held K after SYNC
    enable = 1'b1;
    send_sync("t3");
    snap();
    repeat (5) send_bit(1'b0, 1'b1);
    dp = 1'b0;
    dm = 1'b1;
    repeat (5) @(negedge clk);
    check("t3.err_pre", 32'(bit_stuff_err), 32'd0);
    @(negedge clk);
    check("t3.err_pulse", 32'(bit_stuff_err), 32'd1);
    repeat (2) @(negedge clk);
    send_bit(1'b0, 1'b1);
    #1;
    check("t3.err_count", 32'(n_err - s_err), 32'd1);
    check("t3.bytes", 32'(n_bc - s_bc), 32'd0);
    enable = 1'b0;
    send_bit(1'b1, 1'b0);

    // Partial byte then EOP, then J and a fresh SYNC
    enable = 1'b1;
    send_sync("t4a");
    snap();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    dp = 1'b0;
    dm = 1'b0;
    repeat (5) @(negedge clk);
    check("t4.eop_pre", 32'(eop), 32'd0);
    @(negedge clk);
    check("t4.eop_pulse", 32'(eop), 32'd1);
    repeat (2) @(negedge clk);
    send_bit(1'b1, 1'b0);
    #1;
    check("t4.bytes", 32'(n_bc - s_bc), 32'd0);
    check("t4.eop_count", 32'(n_eop - s_eop), 32'd1);
    send_sync("t4b");
    enable = 1'b0;
    send_bit(1'b1, 1'b0);

    // Reset in the middle of a byte
    enable = 1'b1;
    send_sync("t5a");
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("t5.data", 32'(Packet_Data), 32'h00);
    check("t5.bc", 32'(byte_complete), 32'd0);
    check("t5.eop", 32'(eop), 32'd0);
    check("t5.err", 32'(bit_stuff_err), 32'd0);
    check("t5.edge", 32'(d_edge), 32'd0);
    rst = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    enable = 1'b1;
    send_sync("t5b");

    // Enable dropped mid-byte while the line keeps toggling
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    snap();
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) send_bit(1'b1, 1'b0);
      else            send_bit(1'b0, 1'b1);
    end
    #1;
    check("t6.edges", 32'(n_edge - s_edge), 32'd6);
    check("t6.bytes", 32'(n_bc - s_bc), 32'd0);
    check("t6.eop", 32'(n_eop - s_eop), 32'd0);
    check("t6.err", 32'(n_err - s_err), 32'd0);
    send_bit(1'b1, 1'b0);
    enable = 1'b1;
    send_sync("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_bit_decoder.md
Name: rx_bit_decoder

Overview:
- USB full-speed receive front end, directly upstream of the RX data buffer.
- Samples the synchronised D+/D- lines, recovers bit timing and decodes NRZI.
- Removes stuffed bits, assembles bytes LSB-first and produces Packet_Data / byte_complete.
- Flags EOP and bit-stuff errors to the RCU.

Parameters:
CLKS_PER_BIT, 8, clocks per USB bit period; legal 4..16.
SAMPLE_POINT, 3, counter value at which a bit is sampled; legal 1..CLKS_PER_BIT-2.

Ports:
clk  input  1  system clock.
rst  input  1  reset: synchronous, active-high.
d_plus_sync  input  1  D+ after 2-flop synchroniser.
d_minus_sync  input  1  D- after 2-flop synchroniser.
enable  input  1  RCU receive enable; low = decoder held idle.
d_edge  output  1  1-cycle pulse on any D+ transition (regardless of enable).
Packet_Data  output  8  last assembled byte, LSB = first bit received.
byte_complete  output  1  1-cycle pulse; Packet_Data valid and new in the same cycle.
eop  output  1  1-cycle pulse on a detected EOP.
bit_stuff_err  output  1  1-cycle pulse: a 1 was received where a stuffed 0 was required.

Behaviour:
- Reset (rst high at a clk edge): Packet_Data=0x00, all pulse outputs 0, timer=0, bit_cnt=0, ones_cnt=0, prev_dp=1 (J), state IDLE. rst overrides all other inputs, including mid-byte.
- Edge detect: d_edge=1 in the cycle after d_plus_sync differs from its value one clock earlier.
- Timer: counts 0..CLKS_PER_BIT-1 and wraps. Reloads to 0 on every d_edge.
  - sample strobe when timer==SAMPLE_POINT and state!=IDLE.
  - d_edge and the strobe condition in the same cycle: the reload wins and no sample is taken.
- FSM states:
  - IDLE: enter on rst or enable low; counters cleared; prev_dp=1. Go to RECV when enable is high.
  - RECV: at each strobe:
    - SE0 (both lines 0): go to SE0_1; bit_cnt and ones_cnt cleared; any partial byte discarded.
    - Otherwise: decoded bit = 1 if d_plus_sync==prev_dp, else 0; then prev_dp=d_plus_sync.
  - SE0_1: at the next strobe:
    - SE0 again: eop pulses in the next cycle; go to WAIT_J.
    - Non-SE0: glitch; treat this sample as a normal RECV sample and return to RECV.
  - WAIT_J: at the first strobe seeing J (D+=1, D-=0): prev_dp=1, return to RECV. No bytes are produced while in WAIT_J.
  - enable low in any state: go to IDLE next cycle. No pulses are produced from that cycle on; Packet_Data holds.
- Unstuffing, applied to each decoded bit:
  - ones_cnt is 3 bits: +1 on a 1, cleared on a 0.
  - When ones_cnt==6, the next bit is a stuff bit and is not shifted in; ones_cnt is cleared.
  - If that stuff bit is 1: bit_stuff_err pulses, the bit is dropped, bit_cnt is cleared (partial byte discarded).
- Byte assembly:
  - Data bits shift into shreg[7] and right-shift; bit_cnt counts 0..7.
  - On the 8th data bit, the cycle after the strobe: Packet_Data={bit,shreg[7:1]}, byte_complete=1, bit_cnt=0.
  - Latency: 1 clock from the sampling strobe of the last bit to byte_complete.
  - Packet_Data holds between bytes.
- SYNC KJKJKJKK decodes to 0x80.

Decomposition:
- Package usb_rx_pkg:
  - decoder state enum (IDLE, RECV, SE0_1, WAIT_J);
  - USB_SYNC_BYTE=8'h80;
  - default CLKS_PER_BIT/SAMPLE_POINT constants;
  - J/K/SE0 line-state encoding.
- Sub-module rx_bit_timer: counter with reload-on-edge, enable input and sample-strobe output. Parameterised by CLKS_PER_BIT and SAMPLE_POINT.

Test Plan:
- enable=1, drive SYNC KJKJKJKK at 8 clk/bit -> exactly one byte_complete with Packet_Data=0x80; d_edge pulse on each transition.
- After SYNC, send byte 0xFF encoded with a stuffed 0 after six 1s -> byte_complete, Packet_Data=0xFF; no bit_stuff_err; stuff bit not counted.
- Seven consecutive 1s after SYNC -> bit_stuff_err one pulse on the 7th bit's strobe+1; no byte_complete for that partial byte.
- 3 data bits then SE0 for 2 bit times then J -> no byte_complete; eop one pulse; next SYNC decodes 0x80 again.
- rst high mid-byte (after 5 bits) -> next cycle all outputs 0, Packet_Data=0x00; following full SYNC -> 0x80.
- enable dropped after 4 bits, line keeps toggling -> no byte_complete/eop; d_edge still pulses. Re-enable plus SYNC -> 0x80.
